// File: rtl/mux_pkg.sv
// mux_pkg: shared helpers, state encoding and entry layout for mux_sel_pipe
package mux_pkg;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; (1 << i) < n; i++) r = i + 1;
    return r;
  endfunction
  // Entry packs {err, sel, data} with data in the low bits.
  function automatic int ent_w(input int w, input int sw);
    return w + sw + 1;
  endfunction
endpackage

// File: rtl/mux_n_comb.sv
// mux_n_comb: combinational N:1 selector with out-of-range flag
module mux_n_comb import mux_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NUM_IN = 4,
  localparam int SEL_W = clog2(NUM_IN) < 1 ? 1 : clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data,
  output logic                    err
);
  assign err = int'(sel) >= NUM_IN;
  always_comb begin
    data = '0;
    for (int k = 0; k < NUM_IN; k++) data = (sel == SEL_W'(k)) ? in_data[k*WIDTH +: WIDTH] : data;
  end
endmodule

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: N-way operand selector feeding a two-entry valid/ready output buffer
module mux_sel_pipe import mux_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NUM_IN = 4,
  localparam int SEL_W = clog2(NUM_IN) < 1 ? 1 : clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic [1:0]              count
);
  localparam int EW = ent_w(WIDTH, SEL_W);
  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad
    $error("mux_sel_pipe: NUM_IN must be in 2..16");
  end
  logic [WIDTH-1:0] w_data;
  logic             w_err;
  logic [EW-1:0]    w_ent;
  logic [EW-1:0]    r_head;
  logic [EW-1:0]    r_skid;
  logic [1:0]       r_state;
  logic             r_rdy;
  logic             w_acc;
  logic             w_pop;
  mux_n_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_sel (
    .in_data(in_data),
    .sel(sel),
    .data(w_data),
    .err(w_err)
  );
  assign w_ent = {w_err, sel, w_data};
  // r_rdy keeps in_ready low during reset and releases it one edge later
  assign in_ready = r_rdy && (r_state != ST_FULL);
  assign out_valid = r_state != ST_EMPTY;
  assign count = r_state;
  assign {out_err, out_sel, out_data} = r_head;
  assign w_acc = in_valid && in_ready;
  assign w_pop = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      if (flush) r_state <= ST_EMPTY;
      else case (r_state)
        ST_EMPTY: if (w_acc) begin
          r_head  <= w_ent;
          r_state <= ST_ONE;
        end
        ST_ONE: if (w_acc && w_pop) r_head <= w_ent;
        else if (w_acc) begin
          r_skid  <= w_ent;
          r_state <= ST_FULL;
        end else if (w_pop) r_state <= ST_EMPTY;
        ST_FULL: if (w_pop) begin
          r_head  <= r_skid;
          r_state <= ST_ONE;
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_sel_pipe.sv
// tb_mux_sel_pipe: scoreboard bench for mux_sel_pipe with WIDTH=8, NUM_IN=3
module tb_mux_sel_pipe;
  localparam int W = 8;
  localparam int N = 3;
  typedef struct {
    logic [7:0] d;
    logic [1:0] s;
    logic       e;
  } exp_t;
  logic           clk = 0;
  logic           rst_n = 0;
  logic [N*W-1:0] in_data = '0;
  logic [1:0]     sel = '0;
  logic           in_valid = 0;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_err;
  logic           out_valid;
  logic           out_ready = 0;
  logic           flush = 0;
  logic [1:0]     count;
  int errs = 0;
  int checks = 0;
  bit mon_en = 0;
  exp_t q[$];
  mux_sel_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // One cycle of stimulus; the expected entry is queued once the accepting edge has passed.
  task automatic cyc(input bit v, input logic [1:0] s, input bit ordy, input bit fl,
                     input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_t x;
    bit acc;
    logic [7:0] b[3];
    @(negedge clk);
    b[0] = b0; b[1] = b1; b[2] = b2;
    in_valid = v; sel = s; out_ready = ordy; flush = fl;
    in_data = {b2, b1, b0};
    #1;
    acc = in_valid && in_ready && !flush;
    x.s = s;
    x.e = s >= N;
    x.d = (s < N) ? b[s] : 8'h00;
    @(posedge clk);
    #1;
    if (acc) q.push_back(x);
  endtask
  initial begin : monitor
    exp_t h;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("count", count, q.size());
        chk("in_ready", in_ready, q.size() != 2);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0 && out_valid) begin
          h = q[0];
          chk("out_data", out_data, h.d);
          chk("out_sel", out_sel, h.s);
          chk("out_err", out_err, h.e);
        end
        if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
        if (flush) q.delete();
      end
    end
  end
  initial begin : driver
    in_valid = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 0);
    end
    rst_n = 1;
    in_valid = 0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    mon_en = 1;
    cyc(1, 2, 1, 0, 8'h11, 8'h22, 8'h33);
    cyc(0, 0, 1, 0, 8'h11, 8'h22, 8'h33);
    cyc(0, 0, 1, 0, 8'h11, 8'h22, 8'h33);
    cyc(1, 0, 0, 0, 8'h11, 8'h22, 8'h33);
    cyc(1, 1, 0, 0, 8'h11, 8'h22, 8'h33);
    cyc(1, 2, 0, 0, 8'h11, 8'h22, 8'h33);
    cyc(1, 2, 0, 0, 8'h11, 8'h22, 8'h33);
    cyc(1, 2, 1, 0, 8'h11, 8'h22, 8'h33);
    cyc(1, 2, 1, 0, 8'h11, 8'h22, 8'h33);
    cyc(0, 0, 1, 0, 8'h11, 8'h22, 8'h33);
    cyc(0, 0, 1, 0, 8'h11, 8'h22, 8'h33);
    cyc(1, 3, 0, 0, 8'h11, 8'h22, 8'h33);
    cyc(0, 0, 0, 0, 8'h11, 8'h22, 8'h33);
    cyc(0, 0, 1, 0, 8'h11, 8'h22, 8'h33);
    cyc(1, 0, 0, 0, 8'h11, 8'h22, 8'h33);
    cyc(1, 1, 0, 0, 8'h11, 8'h22, 8'h33);
    cyc(1, 2, 0, 1, 8'h11, 8'h22, 8'h33);
    cyc(0, 0, 1, 0, 8'h11, 8'h22, 8'h33);
    chk("flush_count", count, 0);
    chk("flush_in_ready", in_ready, 1);
    for (int i = 0; i < 9; i++) cyc(1, 2'(i % 3), 1, 0, 8'h11, 8'h22, 8'h33);
    cyc(0, 0, 1, 0, 8'h11, 8'h22, 8'h33);
    cyc(0, 0, 1, 0, 8'h11, 8'h22, 8'h33);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
          $urandom_range(0, 40) == 0, 8'($urandom), 8'($urandom), 8'($urandom));
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
